// File: rtl/nano_uart_loader.sv
// nano_uart_loader: 8N1 UART boot loader that writes a framed program image into memory
// and holds the core in reset while loading. Define NANO_LOADER_CHECKSUM_EN for a trailing XOR byte.
module nano_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_busy,
  output logic              o_err
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [16:0]      MAX_LEN  = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_WAIT_HDR, L_LEN0, L_LEN1, L_DATA, L_CHK, L_DONE} ld_state_t;

  rx_state_t        rx_state, rx_next;
  ld_state_t        ld_state, ld_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_stb, frame_err;

  logic [7:0]       len_lo;
  logic [15:0]      len_full;
  logic [ADDR_W:0]  len, word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic             last_word;
  logic             hdr_ok, len_bad, finish, chk_bad, word_wr;
`ifdef NANO_LOADER_CHECKSUM_EN
  logic [7:0]       chk_acc;
`endif

  always_comb begin
    rx_next   = rx_state;
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (clk_cnt == HALF_BIT) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (clk_cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (clk_cnt == BIT_LAST) begin
        rx_next   = RX_IDLE;
        byte_stb  = rx_sync;
        frame_err = !rx_sync;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Synchroniser, bit timing and shift register; the counter restarts on every state change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_meta  <= i_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_next != rx_state || clk_cnt == BIT_LAST)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + CNT_W'(1);
      if (rx_state == RX_START)
        bit_idx <= '0;
      if (rx_state == RX_DATA && clk_cnt == BIT_LAST) begin
        rx_byte <= {rx_sync, rx_byte[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign len_full  = {rx_byte, len_lo};
  assign last_word = (word_idx + (ADDR_W+1)'(1)) == len;

  always_comb begin
    ld_next = ld_state;
    hdr_ok  = 1'b0;
    len_bad = 1'b0;
    finish  = 1'b0;
    chk_bad = 1'b0;
    word_wr = 1'b0;
    if (byte_stb) begin
      case (ld_state)
        L_WAIT_HDR, L_DONE: if (rx_byte == 8'hA5) begin
          ld_next = L_LEN0;
          hdr_ok  = 1'b1;
        end
        L_LEN0: ld_next = L_LEN1;
        L_LEN1: begin
          if (17'(len_full) > MAX_LEN) begin
            ld_next = L_WAIT_HDR;
            len_bad = 1'b1;
          end else if (len_full == 16'd0) begin
`ifdef NANO_LOADER_CHECKSUM_EN
            ld_next = L_CHK;
`else
            ld_next = L_DONE;
            finish  = 1'b1;
`endif
          end else begin
            ld_next = L_DATA;
          end
        end
        L_DATA: if (byte_cnt == 2'd3) begin
          word_wr = 1'b1;
          if (last_word) begin
`ifdef NANO_LOADER_CHECKSUM_EN
            ld_next = L_CHK;
`else
            ld_next = L_DONE;
            finish  = 1'b1;
`endif
          end
        end
`ifdef NANO_LOADER_CHECKSUM_EN
        L_CHK: begin
          if (rx_byte == chk_acc) begin
            ld_next = L_DONE;
            finish  = 1'b1;
          end else begin
            ld_next = L_WAIT_HDR;
            chk_bad = 1'b1;
          end
        end
`endif
        default: ld_next = L_WAIT_HDR;
      endcase
    end
  end

  // Loader datapath; a word is written the cycle after its fourth byte arrives
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld_state    <= L_WAIT_HDR;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_core_rst  <= 1'b1;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
      len_lo      <= '0;
      len         <= '0;
      word_idx    <= '0;
      byte_cnt    <= '0;
      word_buf    <= '0;
`ifdef NANO_LOADER_CHECKSUM_EN
      chk_acc     <= '0;
`endif
    end else begin
      ld_state <= ld_next;
      o_mem_we <= word_wr;
      if (byte_stb && ld_state == L_LEN0) len_lo <= rx_byte;
      if (byte_stb && ld_state == L_LEN1) len <= len_full[ADDR_W:0];
      if (byte_stb && ld_state == L_DATA) begin
        word_buf <= {rx_byte, word_buf[23:8]};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (word_wr) begin
        o_mem_addr  <= word_idx[ADDR_W-1:0];
        o_mem_wdata <= {rx_byte, word_buf};
        word_idx    <= word_idx + (ADDR_W+1)'(1);
      end
`ifdef NANO_LOADER_CHECKSUM_EN
      if (byte_stb && (ld_state == L_LEN0 || ld_state == L_LEN1 || ld_state == L_DATA))
        chk_acc <= chk_acc ^ rx_byte;
`endif
      if (hdr_ok) begin
        o_core_rst <= 1'b1;
        o_busy     <= 1'b1;
        o_err      <= 1'b0;
        word_idx   <= '0;
        byte_cnt   <= '0;
`ifdef NANO_LOADER_CHECKSUM_EN
        chk_acc    <= '0;
`endif
      end
      if (finish) begin
        o_core_rst <= 1'b0;
        o_busy     <= 1'b0;
      end
      if (len_bad || chk_bad) begin
        o_err  <= 1'b1;
        o_busy <= 1'b0;
      end
      if (frame_err) o_err <= 1'b1;
    end
  end

endmodule
